// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache.
// States, default geometry and bus widths used by the cache top and its arrays.
package data_cache_pkg;

  localparam int DCACHE_LINES = 64;
  localparam int ADDR_W       = 30;
  localparam int DATA_W       = 32;
  localparam int STRB_W       = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } dc_state_t;

endpackage

// File: rtl/data_cache_if.sv
// Memory-side request/response bus of the data cache.
// mem_req_o and its qualifiers are held stable until mem_ack_i; one request outstanding.
interface data_cache_if;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/dcache_mem.sv
// Valid/tag/data arrays of the data cache: combinational read port,
// synchronous byte-masked write port; only valid bits are reset.
module dcache_mem #(
  parameter int LINES = 64,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic             wr_fill,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_be
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
    end else if (wr_en && wr_fill) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // A fill replaces tag and whole word; a store hit only touches strobed bytes.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      if (wr_fill) begin
        tag_q[wr_idx] <= wr_tag;
      end
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          data_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache.
// Optional DCACHE_STATS_EN adds read hit / read miss counters.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINES = DCACHE_LINES,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enabled_i,
  input  logic [31:2]  address_i,
  input  logic [3:0]   write_en_i,
  input  logic [31:0]  data_i,
  output logic [31:0]  data_o,
  output logic         blocking_n_o,
  data_cache_if.master mem,
`ifdef DCACHE_STATS_EN
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o,
`endif
  output dc_state_t    state_o
);

  localparam int TAG_W = 30 - IDX_W;

  dc_state_t        state_q, state_d;
  logic [29:0]      addr_q;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             hit_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  logic [31:0]      line_data;
  logic             hit;
  logic             is_wr;

  logic             blocking_n;
  logic             start_rd;
  logic             start_wr;
  logic             hit_evt;
  logic             arr_wr_en;
  logic             arr_fill;
  logic [31:0]      arr_wr_data;
  logic [3:0]       arr_wr_be;

  assign idx   = address_i[IDX_W+1:2];
  assign tag   = address_i[31:IDX_W+2];
  assign hit   = line_valid && (line_tag == tag);
  assign is_wr = |write_en_i;

  dcache_mem #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_mem (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_idx   (idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (arr_wr_en),
    .wr_fill  (arr_fill),
    .wr_idx   (addr_q[IDX_W-1:0]),
    .wr_tag   (addr_q[29:IDX_W]),
    .wr_data  (arr_wr_data),
    .wr_be    (arr_wr_be)
  );

  always_comb begin
    state_d     = state_q;
    blocking_n  = 1'b1;
    start_rd    = 1'b0;
    start_wr    = 1'b0;
    hit_evt     = 1'b0;
    arr_wr_en   = 1'b0;
    arr_fill    = 1'b0;
    arr_wr_data = wdata_q;
    arr_wr_be   = wstrb_q;
    case (state_q)
      IDLE: begin
        if (enabled_i) begin
          if (is_wr) begin
            blocking_n = 1'b0;
            start_wr   = 1'b1;
            state_d    = WR;
          end else if (hit) begin
            hit_evt    = 1'b1;
          end else begin
            blocking_n = 1'b0;
            start_rd   = 1'b1;
            state_d    = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        blocking_n = 1'b0;
        if (mem.mem_ack_i) begin
          arr_wr_en   = 1'b1;
          arr_fill    = 1'b1;
          arr_wr_data = mem.mem_rdata_i;
          arr_wr_be   = 4'hF;
          state_d     = RESP;
        end
      end
      WR: begin
        blocking_n = 1'b0;
        if (mem.mem_ack_i) begin
          // No allocate: the line is only updated if the store hit when issued.
          arr_wr_en = hit_q;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_rd) begin
        addr_q  <= address_i;
        we_q    <= 1'b0;
        wdata_q <= '0;
        wstrb_q <= '0;
      end else if (start_wr) begin
        addr_q  <= address_i;
        we_q    <= 1'b1;
        wdata_q <= data_i;
        wstrb_q <= write_en_i;
        hit_q   <= hit;
      end
    end
  end

  // Reset must silence the bus and outputs at once, not at the next edge.
  assign mem.mem_req_o   = (state_q == RD_MISS) || (state_q == WR);
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign mem.mem_wstrb_o = wstrb_q;
  assign blocking_n_o    = !rst_i || blocking_n;
  assign data_o          = rst_i ? line_data : 32'h0;
  assign state_o         = state_q;

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit_evt) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (start_rd) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter LINES, default 64, number of one-word direct-mapped lines (power of two, >=2).
REQ-002 SHALL have parameter IDX_W, default $clog2(LINES), the index width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port enabled_i, input, 1, core request valid (driven by the core's data_cache_enabled_o).
REQ-006 SHALL have port address_i, input, 30 [31:2], word address.
REQ-007 SHALL have port write_en_i, input, 4, byte write strobes; 4'b0000 means read.
REQ-008 SHALL have port data_i, input, 32, store data.
REQ-009 SHALL have port data_o, output, 32, load data.
REQ-010 SHALL have port blocking_n_o, output, 1, low = core must hold its request and stall.
REQ-011 SHALL have ports mem_req_o (output, 1), mem_we_o (output, 1), mem_addr_o (output, 30), mem_wdata_o (output, 32), mem_wstrb_o (output, 4): the memory request.
REQ-012 SHALL have ports mem_ack_i (input, 1) and mem_rdata_i (input, 32): the memory response.

Function
REQ-013 SHALL decode the index as address_i[IDX_W+1:2] and the tag as address_i[31:IDX_W+2].
REQ-014 SHALL implement a write-through, no-write-allocate policy with FSM states IDLE, RD_MISS, WR and RESP.
REQ-015 In IDLE with enabled_i=0, SHALL hold blocking_n_o=1 and take no action.
REQ-016 In IDLE on a read hit, SHALL drive blocking_n_o=1 and place the line data combinationally on data_o in the same cycle (0 wait states).
REQ-017 In IDLE on a read miss, SHALL drive blocking_n_o=0 combinationally in the same cycle and go to RD_MISS.
REQ-018 In IDLE on any write (hit or miss), SHALL drive blocking_n_o=0 combinationally and go to WR.
REQ-019 In RD_MISS and WR, SHALL assert mem_req_o=1 with mem_addr_o, mem_we_o, mem_wdata_o and mem_wstrb_o registered and stable until mem_ack_i, and hold blocking_n_o=0.
REQ-020 SHALL accept mem_ack_i as early as the first cycle of mem_req_o; only one request is ever outstanding.
REQ-021 On ack in RD_MISS, SHALL write mem_rdata_i into the line, set its tag and valid bit, and go to RESP.
REQ-022 On ack in WR, SHALL merge write data byte-wise per strobe into the line if it was a hit at request time; a write miss SHALL NOT allocate. The FSM then goes to RESP.
REQ-023 In RESP, SHALL drive blocking_n_o=1 for exactly one cycle, present the line data on data_o for reads, and return to IDLE without reissuing the held write.
REQ-024 SHALL drive mem_req_o=0 in IDLE and RESP.
REQ-025 SHALL give a read hit on a line filled in the previous cycle the new data (no stale read).
REQ-026 SHALL set data_o to the indexed line data whenever no fill is in progress; its value is don't-care when blocking_n_o=0.

Reset
REQ-027 While rst_i=0, SHALL force state=IDLE, clear all valid bits, and drive mem_req_o=0, mem_we_o=0, mem_wstrb_o=0, mem_addr_o=0, mem_wdata_o=0, blocking_n_o=1 and data_o=0.
REQ-028 Reset asserted mid-transaction SHALL abandon the request immediately; a late mem_ack_i after reset is ignored.

Configuration
REQ-029 With DCACHE_STATS_EN defined, SHALL add outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], cleared by reset and wrapping at 2^32.
REQ-030 hit_cnt_o SHALL increment once per IDLE read hit; miss_cnt_o SHALL increment once per IDLE-to-RD_MISS transition.
REQ-031 Without DCACHE_STATS_EN, the counters and ports SHALL be absent and behaviour otherwise identical.

Structure
REQ-032 SHALL take the FSM state encoding and the default LINES constant from the shared core package.
REQ-033 SHALL place the valid/tag/data arrays in one sub-module, dcache_mem (combinational read, synchronous byte-masked write).

Verification
REQ-034 After reset, a read of 0x100 misses; memory acks with 0xDEADBEEF after 3 cycles -> blocking_n_o low for 5 cycles, then RESP with data_o=0xDEADBEEF.
REQ-035 A repeated read of 0x100 -> hit with blocking_n_o=1, data_o=0xDEADBEEF and mem_req_o=0.
REQ-036 A store at 0x100 of 0x000000AA with strobe 0001 -> one memory write with mem_wstrb_o=0001; a subsequent read hit returns 0xDEADBEAA.
REQ-037 A store to uncached 0x200 followed by a read of 0x200 -> the read misses (no allocate) and exactly one memory write is issued.
REQ-038 A read of 0x100+4*LINES (same index, different tag) -> miss and refill; a read of 0x100 then misses again.
REQ-039 Reset asserted while in RD_MISS before ack -> mem_req_o=0 immediately and all lines invalid; with DCACHE_STATS_EN, counters read 0.
